// File: rtl/pwm.sv
// rtl/pwm.sv - free-running PWM generator with registered output
// Define PWM_SHADOW_UPDATE_EN to update the compare value only at period boundaries.
module pwm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] duty_cycle,
    output logic             pwm_out
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty_act;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    // The shadow copy only moves on the last count, so every period runs on one duty value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_act <= '0;
        end else begin
`ifdef PWM_SHADOW_UPDATE_EN
            if (cnt == CNT_MAX) begin
                duty_act <= duty_cycle;
            end
`else
            duty_act <= duty_cycle;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (cnt < duty_act);
        end
    end

endmodule

// File: tb/tb_pwm.sv
// tb/tb_pwm.sv - randomized self-checking bench for pwm against a period-level model
module tb_pwm;

    localparam int W = 8;
    localparam int P = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] duty = '0;
    logic         pwm_out;

    int     n_checks = 0;
    int     n_pass = 0;
    int     k = 0;
    int     hist[$];
    longint last_rise;

    pwm #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .duty_cycle(duty),
        .pwm_out   (pwm_out)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, k);
    endtask

    // Output after the kk-th edge since reset release; hist[j] is duty_cycle seen at edge j+1.
    function automatic int model(input int kk);
        int dact;
        int cpre;
        int p;
        cpre = (kk - 1) % P;
        p = (kk - 1) / P;
`ifdef PWM_SHADOW_UPDATE_EN
        dact = (p == 0) ? 0 : hist[p * P - 1];
`else
        dact = (kk >= 2) ? hist[kk - 2] : 0;
`endif
        return (cpre < dact) ? 1 : 0;
    endfunction

    task automatic step();
        hist.push_back(int'(duty));
        @(posedge clk);
        #1;
        k++;
        check("pwm_cycle", longint'(pwm_out), longint'(model(k)));
    endtask

    task automatic hold_reset(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check("rst_pwm", longint'(pwm_out), 0);
            check("rst_cnt", longint'(dut.cnt), 0);
        end
        @(negedge clk);
        rst = 1'b1;
        k = 0;
        hist.delete();
    endtask

    task automatic run_periods(input int d, input int np);
        int highs;
        duty = W'(d);
        step();
        while (k % P != 0) step();
        last_rise = -1;
        repeat (np) begin
            highs = 0;
            repeat (P) begin
                step();
                if (pwm_out) highs++;
                if (pwm_out && (k % P) == 1) begin
                    if (last_rise >= 0) check("period_ns", $time - last_rise, P * 20);
                    last_rise = $time;
                end
            end
            check("high_count", highs, d);
        end
    endtask

    initial begin
        duty = 8'h80;
        #1;
        check("rst_async_pwm", longint'(pwm_out), 0);
        hold_reset(5);

        duty = '0;
        repeat (512) step();

        run_periods(64, 3);
        run_periods(255, 2);
        run_periods(1, 2);
        run_periods(0, 1);

        // Ramp placed to straddle a period boundary.
        while (k % P != 200) step();
        for (int d = 0; d <= 100; d++) begin
            duty = W'(d);
            step();
        end
        repeat (2 * P) step();

        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) duty = W'($urandom);
            step();
        end
        run_periods(int'($urandom_range(2, 254)), 2);
        run_periods(int'($urandom_range(2, 254)), 2);

        // Reset pulse mid-period while the output is high.
        duty = 8'd200;
        step();
        while (k % P != 0) step();
        while (k % P != 100) step();
        check("pre_rst_high", longint'(pwm_out), 1);
        #5;
        rst = 1'b0;
        #1;
        check("rst_async_pwm", longint'(pwm_out), 0);
        check("rst_async_cnt", longint'(dut.cnt), 0);
        hold_reset(2);
        repeat (2 * P) step();
        run_periods(200, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm.md
PWM -- requirements
Module: pwm

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the counter and duty-cycle width; the period is 2^WIDTH clocks.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port duty_cycle, input, WIDTH bits: unsigned high-time request, in clocks per period.
REQ-005 The block SHALL have port pwm_out, output, 1 bit: registered PWM waveform.

Function
REQ-006 The block SHALL hold an internal WIDTH-bit free-running counter cnt that increments by 1 every clock when rst is high.
REQ-007 cnt SHALL wrap from 2^WIDTH-1 to 0 with no idle cycle, giving a period of exactly 2^WIDTH clocks (256 at default).
REQ-008 The block SHALL hold an internal WIDTH-bit register duty_act, the compare value in use.
REQ-009 On each rising edge, pwm_out SHALL be loaded with (cnt < duty_act), using the pre-edge values of cnt and duty_act.
- Output latency is 1 clock after the compare.
REQ-010 The compare SHALL be unsigned, on full WIDTH bits, with no extension.
REQ-011 duty_act = 0 SHALL hold pwm_out low for the whole period.
REQ-012 duty_act = 2^WIDTH-1 SHALL give pwm_out high for 255 of every 256 clocks and low for 1.
- 100% duty is not reachable.
REQ-013 For any duty_act = D held over a whole period, pwm_out SHALL be high for exactly D consecutive clocks and low for 2^WIDTH-D clocks.
REQ-014 The high phase SHALL begin on the clock after cnt = 0 is compared.
REQ-015 The block SHALL have no glitches: pwm_out changes only on rising clk edges or on assertion of rst.
REQ-016 The block SHALL have no handshake: duty_cycle may change on any cycle.
- Its effect is governed by the Configuration section.

Reset
REQ-017 While rst is low, the block SHALL force cnt = 0, duty_act = 0 and pwm_out = 0 immediately, independent of clk.
REQ-018 After rst deasserts, counting SHALL start on the first rising edge, with cnt going 0 -> 1.
REQ-019 Asserting rst mid-period SHALL abort the period.
- pwm_out goes low at once.
- The next period starts from cnt = 0 after release.

Configuration
REQ-020 Macro PWM_SHADOW_UPDATE_EN, when defined, SHALL make duty_act a shadow register.
- duty_act loads duty_cycle only on the edge where cnt = 2^WIDTH-1.
- A new duty therefore takes effect at the next period boundary.
- No partial periods occur.
- The first period after reset is entirely low.
REQ-021 When PWM_SHADOW_UPDATE_EN is undefined, duty_act SHALL load duty_cycle on every rising edge.
- This gives one extra clock of latency.
- A mid-period change affects the current period immediately.

Verification
REQ-022 rst held low for 5 clocks with duty_cycle = 8'h80 -> pwm_out = 0 and cnt = 0 throughout; pwm_out low asynchronously on rst fall.
REQ-023 rst high, duty_cycle = 0 for 512 clocks -> pwm_out never high.
REQ-024 duty_cycle = 64 steady for 3 periods -> each 256-clock period has exactly 64 high clocks then 192 low clocks; period measured as 5120 ns at a 20 ns clock.
REQ-025 duty_cycle = 255 steady -> exactly 1 low clock per 256-clock period; duty_cycle = 1 -> exactly 1 high clock per period.
REQ-026 duty_cycle incremented by 1 every clock from 0 to 100 (ramp) -> with PWM_SHADOW_UPDATE_EN, the high count of each period equals the duty_cycle sampled at the prior cnt = 255 and there are no partial periods; without it, pwm_out matches the 2-clock-latency compare model every cycle.
REQ-027 rst pulsed low at cnt = 100 with duty_cycle = 200 -> pwm_out drops at once; after release, the next high run starts from cnt = 0 at full length, per the configuration.
